vc_to_d_router: RTL and testbench

VC_TO_D_ROUTER -- requirements
Module: vc_to_d_router

---
 rtl/router_pkg.sv | 14 +
 rtl/vc_arbiter.sv | 53 +++++
 rtl/vc_to_d_router.sv | 139 +++++++++++++
 tb/tb_vc_to_d_router.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/router_pkg.sv
// Shared constants for the VC-to-destination router: FSM encoding and default widths.
package router_pkg;

    localparam int ROUTER_DATA_WIDTH = 6;
    localparam int ROUTER_DEST_BIT   = 4;

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_ERROR  = 2'd3
    } router_state_t;

endpackage

// File: rtl/vc_arbiter.sv
// Picks at most one source VC to pop per cycle.
// ROUTER_RR_EN selects round-robin; otherwise VC0 has strict priority.
module vc_arbiter (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    input  logic req0,
    input  logic req1,
    output logic grant0,
    output logic grant1
);

`ifdef ROUTER_RR_EN
    // prefer1 flips after every grant so a busy VC cannot starve the other one
    logic prefer1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prefer1 <= 1'b0;
        end else if (clear) begin
            prefer1 <= 1'b0;
        end else if (grant0) begin
            prefer1 <= 1'b1;
        end else if (grant1) begin
            prefer1 <= 1'b0;
        end
    end

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (enable) begin
            if (req0 && req1) begin
                grant0 = !prefer1;
                grant1 = prefer1;
            end else begin
                grant0 = req0;
                grant1 = req1;
            end
        end
    end
`else
    logic unused_rr_inputs;
    assign unused_rr_inputs = &{1'b0, clk, rst_n, clear};

    always_comb begin
        grant0 = enable && req0;
        grant1 = enable && req1 && !req0;
    end
`endif

endmodule

// File: rtl/vc_to_d_router.sv
// Moves words from two source VC FIFOs to destination D0/D1 chosen by data[DEST_BIT].
// Build option ROUTER_RR_EN switches the VC arbiter to round-robin.
module vc_to_d_router
    import router_pkg::*;
#(
    parameter int DATA_WIDTH = ROUTER_DATA_WIDTH,
    parameter int DEST_BIT   = ROUTER_DEST_BIT
) (
    input  logic                  clk,
    input  logic                  reset_L,
    input  logic                  init,
    input  logic                  vc0_empty,
    input  logic                  vc1_empty,
    input  logic [DATA_WIDTH-1:0] vc0_data,
    input  logic [DATA_WIDTH-1:0] vc1_data,
    input  logic                  d0_almost_full,
    input  logic                  d1_almost_full,
    input  logic                  d0_full,
    input  logic                  d1_full,
    output logic                  vc0_rd_enable,
    output logic                  vc1_rd_enable,
    output logic                  d0_wr_enable,
    output logic                  d1_wr_enable,
    output logic [DATA_WIDTH-1:0] d0_data,
    output logic [DATA_WIDTH-1:0] d1_data,
    output logic [1:0]            state,
    output logic                  error_out,
    output logic [7:0]            d0_count,
    output logic [7:0]            d1_count
);

    router_state_t         state_q, state_d;
    logic                  pop_ok, grant0, grant1;
    logic                  pend_valid, pend_src;
    logic                  stage_valid;
    logic [DATA_WIDTH-1:0] stage_data;
    logic                  dest_sel, push0, push1, drop;

    assign pop_ok = init && (state_q == ST_IDLE || state_q == ST_ACTIVE)
                    && !d0_almost_full && !d1_almost_full;

    vc_arbiter u_arb (
        .clk    (clk),
        .rst_n  (reset_L),
        .clear  (!init),
        .enable (pop_ok),
        .req0   (!vc0_empty),
        .req1   (!vc1_empty),
        .grant0 (grant0),
        .grant1 (grant1)
    );

    assign vc0_rd_enable = grant0;
    assign vc1_rd_enable = grant1;

    // FIFO read data lags the pop by one cycle, so the source tag waits in pend_* first
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            pend_valid  <= 1'b0;
            pend_src    <= 1'b0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else if (!init) begin
            pend_valid  <= 1'b0;
            pend_src    <= 1'b0;
            stage_valid <= 1'b0;
            stage_data  <= '0;
        end else begin
            pend_valid  <= grant0 || grant1;
            pend_src    <= grant1;
            stage_valid <= pend_valid;
            stage_data  <= pend_src ? vc1_data : vc0_data;
        end
    end

    assign dest_sel = stage_data[DEST_BIT];
    assign push0    = init && stage_valid && !dest_sel && !d0_full;
    assign push1    = init && stage_valid &&  dest_sel && !d1_full;
    assign drop     = init && stage_valid && (dest_sel ? d1_full : d0_full);

    assign d0_wr_enable = push0;
    assign d1_wr_enable = push1;
    assign d0_data      = push0 ? stage_data : '0;
    assign d1_data      = push1 ? stage_data : '0;

    // Counters survive init=0; only the hard reset clears them
    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            error_out <= 1'b0;
            d0_count  <= '0;
            d1_count  <= '0;
        end else begin
            if (!init) begin
                error_out <= 1'b0;
            end else if (drop) begin
                error_out <= 1'b1;
            end
            if (push0) begin
                d0_count <= d0_count + 8'd1;
            end
            if (push1) begin
                d1_count <= d1_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (!init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_INIT: state_d = ST_IDLE;
                ST_IDLE, ST_ACTIVE: begin
                    if (drop) begin
                        state_d = ST_ERROR;
                    end else if (grant0 || grant1) begin
                        state_d = ST_ACTIVE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR: state_d = ST_ERROR;
                default:  state_d = ST_INIT;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_vc_to_d_router.sv
// Scoreboard bench for vc_to_d_router: behavioural source FIFOs feed the DUT,
// expected pushes are queued at load time and popped by a monitor thread.
module tb_vc_to_d_router;
    import router_pkg::*;

    localparam int DW   = ROUTER_DATA_WIDTH;
    localparam int DBIT = ROUTER_DEST_BIT;

    logic          clk = 1'b0;
    logic          reset_L, init;
    logic          vc0_empty, vc1_empty;
    logic [DW-1:0] vc0_data = '0;
    logic [DW-1:0] vc1_data = '0;
    logic          d0_almost_full, d1_almost_full, d0_full, d1_full;
    logic          vc0_rd_enable, vc1_rd_enable, d0_wr_enable, d1_wr_enable;
    logic [DW-1:0] d0_data, d1_data;
    logic [1:0]    state;
    logic          error_out;
    logic [7:0]    d0_count, d1_count;

    typedef struct packed {
        logic          dest;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] fifo0 [0:1023];
    logic [DW-1:0] fifo1 [0:1023];
    int            wr0 = 0, wr1 = 0, rd0 = 0, rd1 = 0;
    logic          flush = 1'b0;
    int            checks = 0, failures = 0;

    always #5 clk = ~clk;

    vc_to_d_router dut (
        .clk            (clk),
        .reset_L        (reset_L),
        .init           (init),
        .vc0_empty      (vc0_empty),
        .vc1_empty      (vc1_empty),
        .vc0_data       (vc0_data),
        .vc1_data       (vc1_data),
        .d0_almost_full (d0_almost_full),
        .d1_almost_full (d1_almost_full),
        .d0_full        (d0_full),
        .d1_full        (d1_full),
        .vc0_rd_enable  (vc0_rd_enable),
        .vc1_rd_enable  (vc1_rd_enable),
        .d0_wr_enable   (d0_wr_enable),
        .d1_wr_enable   (d1_wr_enable),
        .d0_data        (d0_data),
        .d1_data        (d1_data),
        .state          (state),
        .error_out      (error_out),
        .d0_count       (d0_count),
        .d1_count       (d1_count)
    );

    // Source FIFOs with registered read data
    assign vc0_empty = (rd0 >= wr0);
    assign vc1_empty = (rd1 >= wr1);

    always @(posedge clk) begin
        if (flush) begin
            rd0 <= wr0;
            rd1 <= wr1;
        end else begin
            if (vc0_rd_enable) begin
                vc0_data <= fifo0[rd0 % 1024];
                rd0      <= rd0 + 1;
            end
            if (vc1_rd_enable) begin
                vc1_data <= fifo1[rd1 % 1024];
                rd1      <= rd1 + 1;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h required=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int vc, input logic [DW-1:0] w, input bit expect_push);
        exp_t e;
        if (vc == 0) begin
            fifo0[wr0 % 1024] = w;
            wr0++;
        end else begin
            fifo1[wr1 % 1024] = w;
            wr1++;
        end
        if (expect_push) begin
            e.dest = w[DBIT];
            e.data = w;
            sb.push_back(e);
        end
    endtask

    task automatic monitorStep();
        exp_t e;
        if (reset_L) begin
            checkOutput("one_rd_enable", 32'(vc0_rd_enable & vc1_rd_enable), 0);
            checkOutput("rd_when_empty",
                        32'((vc0_rd_enable & vc0_empty) | (vc1_rd_enable & vc1_empty)), 0);
            if (d0_wr_enable || d1_wr_enable) begin
                checkOutput("one_wr_enable", 32'(d0_wr_enable & d1_wr_enable), 0);
                checkOutput("push_expected", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    checkOutput("push_dest", 32'(d1_wr_enable), 32'(e.dest));
                    checkOutput("push_data", 32'(e.dest ? d1_data : d0_data), 32'(e.data));
                    checkOutput("other_data_zero", 32'(e.dest ? d0_data : d1_data), 0);
                end
            end else begin
                checkOutput("idle_data_zero", 32'({d0_data, d1_data}), 0);
            end
        end
    endtask

    task automatic waitDrain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #3;
        checkOutput("drain_timeout", 32'(sb.size()), 0);
    endtask

    initial begin
        reset_L        = 1'b0;
        init           = 1'b0;
        d0_almost_full = 1'b0;
        d1_almost_full = 1'b0;
        d0_full        = 1'b0;
        d1_full        = 1'b0;

        fork
            begin
                forever begin
                    @(posedge clk);
                    #2;
                    monitorStep();
                end
            end
            begin
                // Bring-up, then async reset in the middle of ACTIVE
                repeat (2) @(negedge clk);
                reset_L = 1'b1;
                #1 checkOutput("state_after_reset", 32'(state), 0);
                init = 1'b1;
                @(posedge clk); #1;
                checkOutput("state_idle", 32'(state), 1);
                @(negedge clk);
                applyStimulus(0, 6'h01, 0);
                applyStimulus(0, 6'h02, 0);
                applyStimulus(0, 6'h03, 0);
                @(posedge clk); #1;
                checkOutput("state_active", 32'(state), 2);
                #2 reset_L = 1'b0;
                #1;
                checkOutput("rst_state", 32'(state), 0);
                checkOutput("rst_rd_en", 32'({vc0_rd_enable, vc1_rd_enable}), 0);
                checkOutput("rst_wr_en", 32'({d0_wr_enable, d1_wr_enable}), 0);
                checkOutput("rst_data", 32'({d0_data, d1_data}), 0);
                checkOutput("rst_error", 32'(error_out), 0);
                checkOutput("rst_counts", 32'({d0_count, d1_count}), 0);
                flush = 1'b1;
                repeat (2) @(posedge clk);
                @(negedge clk);
                flush   = 1'b0;
                reset_L = 1'b1;
                @(posedge clk);

                // Two words from VC0 split across D0 and D1 by bit 4
                @(negedge clk);
                applyStimulus(0, 6'h05, 1);
                applyStimulus(0, 6'h15, 1);
                #1 checkOutput("pop_cycle_n", 32'(vc0_rd_enable), 1);
                @(posedge clk); #1;
                checkOutput("no_push_n1", 32'({d0_wr_enable, d1_wr_enable}), 0);
                @(posedge clk); #1;
                checkOutput("d0_push_n2", 32'({d0_wr_enable, d0_data}), 32'({1'b1, 6'h05}));
                @(posedge clk); #1;
                checkOutput("d1_push_n3", 32'({d1_wr_enable, d1_data, d0_data}),
                            32'({1'b1, 6'h15, 6'h00}));
                @(posedge clk); #1;
                checkOutput("counts_1_1", 32'({d0_count, d1_count}), 32'h0101);
                waitDrain(20);

                // Both VCs loaded: arbitration order
                @(negedge clk);
                init = 1'b0;
                @(posedge clk); #1;
                checkOutput("init_low_state", 32'(state), 0);
                @(negedge clk);
                init = 1'b1;
                @(posedge clk);
                @(negedge clk);
`ifdef ROUTER_RR_EN
                applyStimulus(0, 6'h01, 1);
                applyStimulus(1, 6'h11, 1);
                applyStimulus(0, 6'h02, 1);
                applyStimulus(1, 6'h12, 1);
                fifo0[wr0 - 2] = 6'h01;
                fifo0[wr0 - 1] = 6'h02;
                fifo1[wr1 - 2] = 6'h11;
                fifo1[wr1 - 1] = 6'h12;
                #1 checkOutput("arb_first", 32'({vc0_rd_enable, vc1_rd_enable}), 32'b10);
                @(posedge clk); #1;
                checkOutput("arb_second", 32'({vc0_rd_enable, vc1_rd_enable}), 32'b01);
`else
                applyStimulus(0, 6'h01, 1);
                applyStimulus(0, 6'h02, 1);
                applyStimulus(1, 6'h11, 1);
                applyStimulus(1, 6'h12, 1);
                #1 checkOutput("arb_first", 32'({vc0_rd_enable, vc1_rd_enable}), 32'b10);
                @(posedge clk); #1;
                checkOutput("arb_second", 32'({vc0_rd_enable, vc1_rd_enable}), 32'b10);
`endif
                waitDrain(20);
                checkOutput("counts_3_3", 32'({d0_count, d1_count}), 32'h0303);

                // Backpressure from D1 stalls all pops
                @(negedge clk);
                d1_almost_full = 1'b1;
                applyStimulus(0, 6'h04, 1);
                applyStimulus(1, 6'h13, 1);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    checkOutput("af_no_pop", 32'({vc0_rd_enable, vc1_rd_enable}), 0);
                end
                checkOutput("af_state_idle", 32'(state), 1);
                @(negedge clk);
                d1_almost_full = 1'b0;
                #1 checkOutput("af_resume", 32'(vc0_rd_enable), 1);
                waitDrain(20);
                checkOutput("counts_4_4", 32'({d0_count, d1_count}), 32'h0404);

                // Full destination at push time: drop, error, recover via init
                @(negedge clk);
                d0_full = 1'b1;
                applyStimulus(0, 6'h03, 0);
                #1 checkOutput("drop_pop", 32'(vc0_rd_enable), 1);
                @(posedge clk); #1;
                @(posedge clk); #1;
                checkOutput("drop_no_wr", 32'(d0_wr_enable), 0);
                @(posedge clk); #1;
                checkOutput("drop_error", 32'({state, error_out}), 32'({2'd3, 1'b1}));
                @(negedge clk);
                applyStimulus(0, 6'h07, 1);
                for (int i = 0; i < 3; i++) begin
                    @(posedge clk); #1;
                    checkOutput("error_no_pop", 32'(vc0_rd_enable), 0);
                end
                @(negedge clk);
                d0_full = 1'b0;
                init    = 1'b0;
                @(posedge clk); #1;
                checkOutput("recover_state", 32'({state, error_out}), 0);
                checkOutput("recover_counts", 32'({d0_count, d1_count}), 32'h0404);
                @(negedge clk);
                init = 1'b1;
                waitDrain(20);
                checkOutput("counts_5_4", 32'({d0_count, d1_count}), 32'h0504);

                // 256 pushes to D0 wrap its counter
                @(negedge clk);
                reset_L = 1'b0;
                #1 checkOutput("rst2_counts", 32'({d0_count, d1_count}), 0);
                @(negedge clk);
                reset_L = 1'b1;
                @(posedge clk);
                @(negedge clk);
                for (int i = 0; i < 256; i++) begin
                    logic [DW-1:0] w;
                    w = DW'(i) & 6'h2F;
                    applyStimulus(0, w, 1);
                end
                waitDrain(600);
                checkOutput("wrap_counts", 32'({d0_count, d1_count}), 0);

                $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
                $finish;
            end
        join_any
    end

endmodule
